// File: rtl/morse_char_decoder.sv
// rtl/morse_char_decoder.sv - morse character to ASCII decoder with output FIFO
//
// Purpose: takes per-character results from the morse capture stage and turns
// each one into an ASCII byte. A space is emitted at word boundaries. Bytes are
// queued in a first-word-fall-through FIFO with a valid/ready output.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear (FIFO flush, FSM idle, overrun cleared)
//   in_stb       one-cycle character/word event strobe
//   in_len       symbol count of the character
//   in_code      symbol history, bit0 newest, 1 = dah
//   in_error     capture error flag
//   in_word_end  1 = word-end event, 0 = character-end event
//   out_data     ASCII byte at FIFO head (0 when empty)
//   out_valid    FIFO not empty
//   out_ready    consumer accepts out_data
//   fifo_count   FIFO occupancy
//   overrun      sticky: a strobe arrived while busy and was dropped
//   busy         FSM not idle
module morse_char_decoder #(
    parameter int          MAX_LEN  = 6,
    parameter int          LEN_W    = 3,
    parameter int          DEPTH    = 8,
    parameter logic [7:0]  ERR_CHAR = 8'h23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_stb,
    input  logic [LEN_W-1:0]         in_len,
    input  logic [MAX_LEN-1:0]       in_code,
    input  logic                     in_error,
    input  logic                     in_word_end,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_LOOKUP     = 2'd1,
        S_PUSH_CHAR  = 2'd2,
        S_PUSH_SPACE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [LEN_W-1:0]    r_len;
    logic [MAX_LEN-1:0]  r_code;
    logic                r_error;
    logic                r_word_end;
    logic                r_space_pending;
    logic                r_word_active;
    logic [7:0]          r_char;
    logic                r_overrun;

    logic [7:0]          r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_push_data;
    logic [MAX_LEN-1:0]  w_masked;
    logic [8:0]          w_lookup;
    logic                w_len_ok;
    logic                w_accept;

    // {hit, ascii} for a {length, pattern} key; first symbol sits at bit len-1.
    function automatic logic [8:0] lookup(input logic [8:0] key);
        logic [8:0] r;
        case (key)
            {3'd2, 6'b000001}: r = {1'b1, 8'h41}; // A .-
            {3'd4, 6'b001000}: r = {1'b1, 8'h42}; // B -...
            {3'd4, 6'b001010}: r = {1'b1, 8'h43}; // C -.-.
            {3'd3, 6'b000100}: r = {1'b1, 8'h44}; // D -..
            {3'd1, 6'b000000}: r = {1'b1, 8'h45}; // E .
            {3'd4, 6'b000010}: r = {1'b1, 8'h46}; // F ..-.
            {3'd3, 6'b000110}: r = {1'b1, 8'h47}; // G --.
            {3'd4, 6'b000000}: r = {1'b1, 8'h48}; // H ....
            {3'd2, 6'b000000}: r = {1'b1, 8'h49}; // I ..
            {3'd4, 6'b000111}: r = {1'b1, 8'h4A}; // J .---
            {3'd3, 6'b000101}: r = {1'b1, 8'h4B}; // K -.-
            {3'd4, 6'b000100}: r = {1'b1, 8'h4C}; // L .-..
            {3'd2, 6'b000011}: r = {1'b1, 8'h4D}; // M --
            {3'd2, 6'b000010}: r = {1'b1, 8'h4E}; // N -.
            {3'd3, 6'b000111}: r = {1'b1, 8'h4F}; // O ---
            {3'd4, 6'b000110}: r = {1'b1, 8'h50}; // P .--.
            {3'd4, 6'b001101}: r = {1'b1, 8'h51}; // Q --.-
            {3'd3, 6'b000010}: r = {1'b1, 8'h52}; // R .-.
            {3'd3, 6'b000000}: r = {1'b1, 8'h53}; // S ...
            {3'd1, 6'b000001}: r = {1'b1, 8'h54}; // T -
            {3'd3, 6'b000001}: r = {1'b1, 8'h55}; // U ..-
            {3'd4, 6'b000001}: r = {1'b1, 8'h56}; // V ...-
            {3'd3, 6'b000011}: r = {1'b1, 8'h57}; // W .--
            {3'd4, 6'b001001}: r = {1'b1, 8'h58}; // X -..-
            {3'd4, 6'b001011}: r = {1'b1, 8'h59}; // Y -.--
            {3'd4, 6'b001100}: r = {1'b1, 8'h5A}; // Z --..
            {3'd5, 6'b011111}: r = {1'b1, 8'h30}; // 0
            {3'd5, 6'b001111}: r = {1'b1, 8'h31}; // 1
            {3'd5, 6'b000111}: r = {1'b1, 8'h32}; // 2
            {3'd5, 6'b000011}: r = {1'b1, 8'h33}; // 3
            {3'd5, 6'b000001}: r = {1'b1, 8'h34}; // 4
            {3'd5, 6'b000000}: r = {1'b1, 8'h35}; // 5
            {3'd5, 6'b010000}: r = {1'b1, 8'h36}; // 6
            {3'd5, 6'b011000}: r = {1'b1, 8'h37}; // 7
            {3'd5, 6'b011100}: r = {1'b1, 8'h38}; // 8
            {3'd5, 6'b011110}: r = {1'b1, 8'h39}; // 9
            default:           r = {1'b0, 8'h00};
        endcase
        return r;
    endfunction

    // Bits at or above the length are stale history from earlier characters.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(r_len)) begin
                w_masked[i] = r_code[i];
            end
        end
    end

    assign w_len_ok = (int'(r_len) != 0) && (int'(r_len) <= MAX_LEN);
    assign w_lookup = lookup({3'(r_len), 6'(w_masked)});
    assign w_accept = (r_state == S_IDLE) && in_stb && !clr;

    // FIFO status
    assign w_full     = (r_count == CW'(DEPTH));
    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid && out_ready && !clr;
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_count = r_count;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        if (clr) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_stb) begin
                        if (!in_word_end) begin
                            w_next = S_LOOKUP;
                        end else if (in_error) begin
                            w_next = S_PUSH_CHAR;
                        end else if (r_word_active) begin
                            w_next = S_PUSH_SPACE;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end
                end
                S_LOOKUP: w_next = S_PUSH_CHAR;
                S_PUSH_CHAR: begin
                    if (!w_full) begin
                        w_next = r_space_pending ? S_PUSH_SPACE : S_IDLE;
                    end
                end
                S_PUSH_SPACE: begin
                    if (!w_full) begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // FSM outputs: FIFO write request and data
    always_comb begin
        w_push      = 1'b0;
        w_push_data = r_char;
        case (r_state)
            S_PUSH_CHAR: begin
                w_push = !w_full && !clr;
            end
            S_PUSH_SPACE: begin
                w_push      = !w_full && !clr;
                w_push_data = 8'h20;
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
    end

    // Captured event, decoded character, word tracking, overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len           <= '0;
            r_code          <= '0;
            r_error         <= 1'b0;
            r_word_end      <= 1'b0;
            r_space_pending <= 1'b0;
            r_word_active   <= 1'b0;
            r_char          <= 8'h00;
            r_overrun       <= 1'b0;
        end else if (clr) begin
            r_space_pending <= 1'b0;
            r_word_active   <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len      <= in_len;
                r_code     <= in_code;
                r_error    <= in_error;
                r_word_end <= in_word_end;
                // An abort only closes the word with a space if a word was open.
                r_space_pending <= in_word_end && r_word_active;
                // Abort path goes straight to PUSH_CHAR with the error byte.
                r_char <= ERR_CHAR;
            end
            if (r_state == S_LOOKUP) begin
                r_char <= (w_lookup[8] && w_len_ok && !r_error) ? w_lookup[7:0] : ERR_CHAR;
            end
            if (w_push && (r_state == S_PUSH_CHAR) && !r_word_end) begin
                r_word_active <= 1'b1;
            end
            if (w_push && (r_state == S_PUSH_SPACE)) begin
                r_word_active <= 1'b0;
            end
            if (in_stb && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // FIFO pointers and occupancy; full is judged before any same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
